// File: rtl/alluvial_mc.sv
// alluvial_mc: multi-cycle ALU sitting between the instruction decoder and the
// writeback stage. ADD/SUB/AND/OR/XOR complete in one cycle. MUL (shift-add)
// and DIV (restoring) take one bit per cycle, WIDTH cycles in BUSY.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   producer presents op/a/b
//   in_ready   block can accept an operation (IDLE and not in reset)
//   op         0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=MUL 6=DIV, anything else illegal
//   a, b       unsigned operands
//   out_valid  result/error valid
//   out_ready  consumer takes the result
//   result     operation result
//   error      ADD carry, SUB borrow, MUL overflow, DIV by zero, illegal op
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand transfer
// BUSY  | MUL/DIV iterating, one bit per cycle
// DONE  | result held on the outputs until out_ready
module alluvial_mc #(
   parameter int WIDTH    = 8,
   parameter int OP_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_WIDTH-1:0] op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    result,
   output logic                error
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(6);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [CNT_W-1:0] cnt;
   logic             mul_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   // work_hi: MUL partial-product high half / DIV partial remainder
   // work_lo: MUL multiplier shifting out / DIV dividend in, quotient out
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;

   logic             accept;
   logic             op_iter;
   logic             last_iter;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH-1:0] single_res;
   logic             single_err;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_nx;
   logic [WIDTH-1:0] mul_lo_nx;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;
   logic [WIDTH-1:0] div_hi_nx;
   logic [WIDTH-1:0] div_lo_nx;
   logic [WIDTH-1:0] iter_hi_nx;
   logic [WIDTH-1:0] iter_lo_nx;

   assign in_ready  = (state == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   // Divide by zero is resolved at accept, so only real work enters BUSY
   assign op_iter   = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = op_iter ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      add_sum    = {1'b0, a} + {1'b0, b};
      sub_diff   = {1'b0, a} - {1'b0, b};
      single_res = '0;
      single_err = 1'b0;
      case (op)
         OP_ADD: begin
            single_res = add_sum[WIDTH-1:0];
            single_err = add_sum[WIDTH];
         end
         OP_SUB: begin
            single_res = sub_diff[WIDTH-1:0];
            single_err = sub_diff[WIDTH];
         end
         OP_AND: single_res = a & b;
         OP_OR:  single_res = a | b;
         OP_XOR: single_res = a ^ b;
         OP_DIV: begin
            single_res = '1;
            single_err = 1'b1;
         end
         OP_MUL: begin
            single_res = '0;
            single_err = 1'b0;
         end
         default: begin
            single_res = '0;
            single_err = 1'b1;
         end
      endcase
   end

   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : '0);
      mul_hi_nx = mul_sum[WIDTH:1];
      mul_lo_nx = {mul_sum[0], work_lo[WIDTH-1:1]};

      div_shift = {work_hi, work_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      // When div_ge holds the difference is below b, so the low WIDTH bits suffice
      div_sub   = div_shift[WIDTH-1:0] - b_q;
      div_hi_nx = div_ge ? div_sub : div_shift[WIDTH-1:0];
      div_lo_nx = {work_lo[WIDTH-2:0], div_ge};

      iter_hi_nx = mul_q ? mul_hi_nx : div_hi_nx;
      iter_lo_nx = mul_q ? mul_lo_nx : div_lo_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         mul_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         work_hi   <= '0;
         work_lo   <= '0;
         result    <= '0;
         error     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt     <= '0;
                  mul_q   <= (op == OP_MUL);
                  a_q     <= a;
                  b_q     <= b;
                  work_hi <= '0;
                  work_lo <= (op == OP_MUL) ? b : a;
                  if (!op_iter) begin
                     result <= single_res;
                     error  <= single_err;
                  end
               end
            end
            BUSY: begin
               cnt     <= cnt + CNT_W'(1);
               work_hi <= iter_hi_nx;
               work_lo <= iter_lo_nx;
               if (last_iter) begin
                  result <= iter_lo_nx;
                  error  <= mul_q ? (iter_hi_nx != '0) : 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
